booth_seq_ctrl: RTL and testbench
=================================

// Module: booth_seq_ctrl
// PURPOSE
//   Radix-2 Booth multiply sequencer built around the shared AddSub datapath unit.
//   It accepts a signed WIDTH x WIDTH operand pair with a start/ready handshake and
//   drives the external AddSub ports (a, b, ctrl) one Booth step at a time.
//   It returns a 2*WIDTH signed product with a one-cycle done pulse.
//   It sits between the top-level multiplier wrapper and the AddSub instance.
// PARAMETERS
//   WIDTH    4  operand width in bits; this is also the AddSub width
//   ADD_LAT  1  cycles from stable AddSub inputs to valid as_o (0 = combinational)
// PORTS
//   clk           in   1        system clock, rising edge
//   rst           in   1        asynchronous, active-high reset
//   start         in   1        request a multiply; sampled only when ready=1
//   ready         out  1        controller is idle and will accept start
//   busy          out  1        a multiply is in progress (equals ~ready)
//   multiplicand  in   WIDTH    M, two's complement; captured on accepted start
//   multiplier    in   WIDTH    Q, two's complement; captured on accepted start
//   product       out  2*WIDTH  signed result {A,Q}; held until the next accepted start
//   done          out  1        one-cycle pulse; product is valid in the same cycle
//   as_a          out  WIDTH    AddSub operand a (accumulator A)
//   as_b          out  WIDTH    AddSub operand b (multiplicand M)
//   as_ctrl       out  1        AddSub op select: 0 = add, 1 = subtract
//   as_o          in   WIDTH    AddSub result, mod 2^WIDTH
// BEHAVIOUR
//   Reset values: state=IDLE, ready=1, busy=0, done=0, product=0.
//     A, Q, Q_1, M, the iteration count and the wait count are all cleared.
//     as_a=0, as_b=0, as_ctrl=0.
//   Reset mid-operation aborts immediately. No done pulse is issued and product reads 0.
//   FSM IDLE -> EXAM -> [WAIT] -> EXAM ... -> DONE -> IDLE.
//   IDLE: on start=1, load M<=multiplicand, Q<=multiplier, A<=0, Q_1<=0, cnt<=0, go to EXAM.
//     start while busy is ignored; it is neither queued nor allowed to corrupt state.
//   EXAM: decode {Q[0],Q_1}.
//     00 or 11: no operation. Arithmetic-shift-right {A,Q,Q_1} in this cycle.
//     01: add, as_ctrl=0. 10: subtract, as_ctrl=1.
//     If ADD_LAT==0, shift with the as_o result in this cycle.
//     Otherwise go to WAIT with wcnt=ADD_LAT.
//   WAIT: hold as_a, as_b and as_ctrl stable. Decrement wcnt.
//     When wcnt==1, capture as_o, perform the shift, and return to EXAM.
//   Shift with a sum: the bit shifted into A[WIDTH-1] is as_o[WIDTH-1] ^ ovf.
//     ovf is two's-complement overflow of the AddSub op, computed from the as_a,
//     as_b and as_ctrl signs and the as_o sign. This makes M = -2^(WIDTH-1) exact.
//   Every shift increments cnt. After the shift with cnt==WIDTH-1, go to DONE.
//   DONE: product<={A,Q}, done=1 for exactly one cycle, then go to IDLE.
//     ready rises in the cycle after done.
//   Latency: start accepted on edge t -> done high in cycle t+WIDTH+1+ADD_LAT*N.
//     N is the number of 01/10 pairs in the multiplier bit string with Q_1=0 appended.
//   as_a and as_b are driven from the A and M registers in all states. They are
//     don't-care outside EXAM/WAIT, but they never glitch while in WAIT.
//   The product is exact for every signed pair; there are no saturation cases.
// STRUCTURE
//   Shared include booth_defs.vh contains:
//     state encodings S_IDLE, S_EXAM, S_WAIT, S_DONE;
//     OP_ADD=1'b0, OP_SUB=1'b1;
//     the Booth pair codes.
//   Sub-module booth_shift_step (combinational) takes {A,Q,Q_1}, the sum, the
//     use_sum flag and ovf, and produces the shifted {A,Q,Q_1}.
//   AddSub stays outside this block and is wired up by the top-level wrapper.
// TESTING (WIDTH=4; unit under test wired to AddSub; cycle checks use ADD_LAT=1)
//   3 x 2 -> product=8'h06; done 7 cycles after start (N=2).
//   -8 x -8 -> product=8'h40; exercises the ovf shift path.
//   -8 x 7 -> product=8'hC8 (-56); done 7 cycles after start (N=2).
//   5 x 0 -> product=8'h00; done exactly 5 cycles after start; as_ctrl never toggles.
//   start pulsed again in the cycle after acceptance (operands 1,1) -> ignored;
//     the first result completes, and ready=0 until done.
//   rst asserted in WAIT -> next edge shows IDLE and ready=1, with no done pulse.
//     A following 7 x 7 then gives 8'h31.
//   Exhaustive 16x16 signed sweep at ADD_LAT=0 and at ADD_LAT=2 -> every product
//     equals a*b.

Source files
------------

// File: rtl/booth_seq_ctrl_pkg.sv
// Shared types and helpers for the radix-2 Booth multiply sequencer.
// State encodings, AddSub op codes, Booth pair codes and the overflow rule.
package booth_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXAM = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Booth pair codes, indexed as {Q[0], Q_1}
   localparam logic [1:0] PAIR_NOP0 = 2'b00;
   localparam logic [1:0] PAIR_ADD  = 2'b01;
   localparam logic [1:0] PAIR_SUB  = 2'b10;
   localparam logic [1:0] PAIR_NOP1 = 2'b11;

   function automatic int clog2_min1(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

   // Subtract is a + ~b + 1, so the effective sign of b flips for OP_SUB.
   function automatic logic addsub_ovf(input logic a_s, input logic b_s,
                                       input logic op, input logic o_s);
      logic b_eff;
      b_eff = b_s ^ op;
      return (a_s == b_eff) && (o_s != a_s);
   endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Operand/result handshake plus the external AddSub port bundle.
// The sequencer uses the slave modport; the wrapper/AddSub side uses master.
interface booth_seq_ctrl_if #(
   parameter int WIDTH = 4
);
   logic               start;
   logic               ready;
   logic               busy;
   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic [2*WIDTH-1:0] product;
   logic               done;
   logic [WIDTH-1:0]   as_a;
   logic [WIDTH-1:0]   as_b;
   logic               as_ctrl;
   logic [WIDTH-1:0]   as_o;

   modport slave (
      input  start, multiplicand, multiplier, as_o,
      output ready, busy, product, done, as_a, as_b, as_ctrl
   );

   modport master (
      output start, multiplicand, multiplier, as_o,
      input  ready, busy, product, done, as_a, as_b, as_ctrl
   );
endinterface

// File: rtl/booth_shift_step.sv
// One Booth arithmetic right shift of {A,Q,Q_1}, optionally taking A from the AddSub sum.
// The new A sign comes from the sum sign corrected by overflow, keeping the result exact.
module booth_shift_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             q1_i,
   input  logic [WIDTH-1:0] sum_i,
   input  logic             use_sum_i,
   input  logic             ovf_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] q_o,
   output logic             q1_o
);
   logic [WIDTH-1:0] a_src;
   logic             msb;

   always_comb begin
      a_src = a_i;
      msb   = a_i[WIDTH-1];
      if (use_sum_i) begin
         a_src = sum_i;
         msb   = sum_i[WIDTH-1] ^ ovf_i;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign a_o[gi] = a_src[gi+1];
         assign q_o[gi] = q_i[gi+1];
      end
   endgenerate

   assign a_o[WIDTH-1] = msb;
   assign q_o[WIDTH-1] = a_src[0];
   assign q1_o         = q_i[0];

   // q1_i is consumed by the caller's pair decode; the shift itself discards it
   logic unused_q1;
   assign unused_q1 = q1_i;
endmodule

// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth multiply sequencer driving an external AddSub unit one step at a time.
// ADD_LAT selects combinational (0) or pipelined AddSub timing via a WAIT state.
module booth_seq_ctrl
   import booth_seq_ctrl_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int ADD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   booth_seq_ctrl_if.slave  ctrl_if
);
   localparam int CNT_W  = clog2_min1(WIDTH);
   localparam int WCNT_W = clog2_min1(ADD_LAT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
   localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(ADD_LAT);

   state_t               state_q,   state_d;
   logic [WIDTH-1:0]     a_q,       a_d;
   logic [WIDTH-1:0]     q_q,       q_d;
   logic                 q1_q,      q1_d;
   logic [WIDTH-1:0]     m_q,       m_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [WCNT_W-1:0]    wcnt_q,    wcnt_d;
   logic                 op_q,      op_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [1:0]           pair;
   logic                 exam_arith;
   logic                 exam_op;
   logic                 as_ctrl;
   logic                 ovf;
   logic                 use_sum;
   logic                 do_shift;
   logic [WIDTH-1:0]     sh_a;
   logic [WIDTH-1:0]     sh_q;
   logic                 sh_q1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         m_q       <= '0;
         cnt_q     <= '0;
         wcnt_q    <= '0;
         op_q      <= OP_ADD;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         m_q       <= m_d;
         cnt_q     <= cnt_d;
         wcnt_q    <= wcnt_d;
         op_q      <= op_d;
         product_q <= product_d;
      end
   end

   assign pair       = {q_q[0], q1_q};
   assign exam_arith = (pair == PAIR_ADD) || (pair == PAIR_SUB);
   assign exam_op    = (pair == PAIR_SUB) ? OP_SUB : OP_ADD;

   // During WAIT the op comes from a register so the AddSub inputs stay frozen
   always_comb begin
      case (state_q)
         S_EXAM:  as_ctrl = exam_op;
         S_WAIT:  as_ctrl = op_q;
         default: as_ctrl = OP_ADD;
      endcase
   end

   assign ovf = addsub_ovf(a_q[WIDTH-1], m_q[WIDTH-1], as_ctrl, ctrl_if.as_o[WIDTH-1]);

   booth_shift_step #(.WIDTH(WIDTH)) u_step (
      .a_i       (a_q),
      .q_i       (q_q),
      .q1_i      (q1_q),
      .sum_i     (ctrl_if.as_o),
      .use_sum_i (use_sum),
      .ovf_i     (ovf),
      .a_o       (sh_a),
      .q_o       (sh_q),
      .q1_o      (sh_q1)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      q1_d      = q1_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      wcnt_d    = wcnt_q;
      op_d      = op_q;
      product_d = product_q;
      use_sum   = 1'b0;
      do_shift  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ctrl_if.start) begin
               m_d     = ctrl_if.multiplicand;
               q_d     = ctrl_if.multiplier;
               a_d     = '0;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_EXAM;
            end
         end
         S_EXAM: begin
            if (!exam_arith) begin
               do_shift = 1'b1;
            end else if (ADD_LAT == 0) begin
               do_shift = 1'b1;
               use_sum  = 1'b1;
            end else begin
               op_d    = exam_op;
               wcnt_d  = WCNT_LOAD;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            wcnt_d = wcnt_q - WCNT_W'(1);
            if (wcnt_q == WCNT_W'(1)) begin
               do_shift = 1'b1;
               use_sum  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Product is loaded on the way into DONE so it is valid alongside the done pulse
      if (do_shift) begin
         a_d   = sh_a;
         q_d   = sh_q;
         q1_d  = sh_q1;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            state_d   = S_DONE;
            product_d = {sh_a, sh_q};
         end else begin
            state_d   = S_EXAM;
         end
      end
   end

   assign ctrl_if.ready   = (state_q == S_IDLE);
   assign ctrl_if.busy    = (state_q != S_IDLE);
   assign ctrl_if.done    = (state_q == S_DONE);
   assign ctrl_if.product = product_q;
   assign ctrl_if.as_a    = a_q;
   assign ctrl_if.as_b    = m_q;
   assign ctrl_if.as_ctrl = as_ctrl;
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl at WIDTH=4 with AddSub latencies 0, 1 and 2.
// Each instance gets its own interface and a behavioural AddSub of matching latency.
module tb_booth_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   int         sel     = 1;
   logic       start_s = 1'b0;
   logic [3:0] mcand   = '0;
   logic [3:0] mplier  = '0;

   booth_seq_ctrl_if #(.WIDTH(4)) if0 ();
   booth_seq_ctrl_if #(.WIDTH(4)) if1 ();
   booth_seq_ctrl_if #(.WIDTH(4)) if2 ();

   booth_seq_ctrl #(.WIDTH(4), .ADD_LAT(0)) u0 (.clk(clk), .rst(rst), .ctrl_if(if0.slave));
   booth_seq_ctrl #(.WIDTH(4), .ADD_LAT(1)) u1 (.clk(clk), .rst(rst), .ctrl_if(if1.slave));
   booth_seq_ctrl #(.WIDTH(4), .ADD_LAT(2)) u2 (.clk(clk), .rst(rst), .ctrl_if(if2.slave));

   assign if0.start = start_s && (sel == 0);
   assign if1.start = start_s && (sel == 1);
   assign if2.start = start_s && (sel == 2);
   assign if0.multiplicand = mcand;
   assign if1.multiplicand = mcand;
   assign if2.multiplicand = mcand;
   assign if0.multiplier = mplier;
   assign if1.multiplier = mplier;
   assign if2.multiplier = mplier;

   // Behavioural AddSub units: combinational, one stage and two stages
   logic [3:0] as1_q, as2a_q, as2b_q;
   assign if0.as_o = if0.as_ctrl ? (if0.as_a - if0.as_b) : (if0.as_a + if0.as_b);
   always @(posedge clk) begin
      as1_q  <= if1.as_ctrl ? (if1.as_a - if1.as_b) : (if1.as_a + if1.as_b);
      as2a_q <= if2.as_ctrl ? (if2.as_a - if2.as_b) : (if2.as_a + if2.as_b);
      as2b_q <= as2a_q;
   end
   assign if1.as_o = as1_q;
   assign if2.as_o = as2b_q;

   logic       done_m, ready_m, busy_m, as_ctrl_m;
   logic [7:0] product_m;
   always_comb begin
      done_m = if1.done; ready_m = if1.ready; busy_m = if1.busy;
      as_ctrl_m = if1.as_ctrl; product_m = if1.product;
      if (sel == 0) begin
         done_m = if0.done; ready_m = if0.ready; busy_m = if0.busy;
         as_ctrl_m = if0.as_ctrl; product_m = if0.product;
      end else if (sel == 2) begin
         done_m = if2.done; ready_m = if2.ready; busy_m = if2.busy;
         as_ctrl_m = if2.as_ctrl; product_m = if2.product;
      end
   end

   // Stimulus driver only: starts one multiply, returns product, done cycle and as_ctrl toggles
   task automatic run_op(input int s, input logic [3:0] m, input logic [3:0] q,
                         output logic [7:0] p, output int cyc, output int tog);
      logic prev;
      int   k;
      sel = s; mcand = m; mplier = q; start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      k = 1; tog = 0; prev = as_ctrl_m;
      while (done_m !== 1'b1 && k < 200) begin
         @(posedge clk); #1;
         k++;
         if (as_ctrl_m !== prev) tog++;
         prev = as_ctrl_m;
      end
      cyc = (done_m === 1'b1) ? k : -1;
      p   = product_m;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (if1.ready !== 1'b1 || if1.busy !== 1'b0 || if1.done !== 1'b0) begin
         nerr++;
         $display("FAIL reset_flags: ready=%b busy=%b done=%b, required 1 0 0",
                  if1.ready, if1.busy, if1.done);
      end
      nvec++;
      if (if1.product !== 8'h00 || if1.as_a !== 4'h0 || if1.as_b !== 4'h0 || if1.as_ctrl !== 1'b0) begin
         nerr++;
         $display("FAIL reset_values: product=%h as_a=%h as_b=%h as_ctrl=%b, required 00 0 0 0",
                  if1.product, if1.as_a, if1.as_b, if1.as_ctrl);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [7:0] p;
      int cyc, tog;
      logic [3:0] mv [4] = '{4'd3, 4'h8, 4'h8, 4'd5};
      logic [3:0] qv [4] = '{4'd2, 4'h8, 4'd7, 4'd0};
      logic [7:0] pe [4] = '{8'h06, 8'h40, 8'hC8, 8'h00};
      int         ce [4] = '{7, 6, 7, 5};
      for (int i = 0; i < 4; i++) begin
         run_op(1, mv[i], qv[i], p, cyc, tog);
         $display("lat1 %0d x %0d -> product=%h done_cycle=%0d", $signed(mv[i]), $signed(qv[i]), p, cyc);
         nvec++;
         if (p !== pe[i]) begin
            nerr++;
            $display("FAIL product_%0d: got %h, required %h", i, p, pe[i]);
         end
         nvec++;
         if (cyc != ce[i]) begin
            nerr++;
            $display("FAIL latency_%0d: got %0d, required %0d", i, cyc, ce[i]);
         end
         if (i == 3) begin
            nvec++;
            if (tog != 0) begin
               nerr++;
               $display("FAIL ctrl_quiet: as_ctrl toggled %0d times, required 0", tog);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int k;
      int bad_ready;
      sel = 1; mcand = 4'd3; mplier = 4'd2; start_s = 1'b1;
      @(posedge clk); #1;
      mcand = 4'd1; mplier = 4'd1;
      k = 1; bad_ready = 0;
      if (ready_m !== 1'b0) bad_ready++;
      @(posedge clk); #1;
      start_s = 1'b0;
      k = 2;
      while (done_m !== 1'b1 && k < 200) begin
         if (ready_m !== 1'b0) bad_ready++;
         @(posedge clk); #1;
         k++;
      end
      $display("b2b 3 x 2 with extra start -> product=%h done_cycle=%0d", product_m, k);
      nvec++;
      if (bad_ready != 0) begin
         nerr++;
         $display("FAIL b2b_ready: ready high in %0d busy cycles, required 0", bad_ready);
      end
      nvec++;
      if (product_m !== 8'h06 || k != 7) begin
         nerr++;
         $display("FAIL b2b_result: product=%h cycle=%0d, required 06 7", product_m, k);
      end
      @(posedge clk); #1;
      nvec++;
      if (ready_m !== 1'b1) begin
         nerr++;
         $display("FAIL b2b_ready_after: ready=%b, required 1", ready_m);
      end
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if (busy_m !== 1'b0) begin
         nerr++;
         $display("FAIL b2b_not_queued: busy=%b, required 0", busy_m);
      end
   endtask

   task automatic test_reset_in_wait();
      logic [7:0] p;
      int cyc, tog;
      sel = 1; mcand = 4'd3; mplier = 4'd2; start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (busy_m !== 1'b1 || as_ctrl_m !== 1'b1) begin
         nerr++;
         $display("FAIL wait_reached: busy=%b as_ctrl=%b, required 1 1", busy_m, as_ctrl_m);
      end
      rst = 1'b1;
      #1;
      nvec++;
      if (ready_m !== 1'b1 || done_m !== 1'b0 || product_m !== 8'h00) begin
         nerr++;
         $display("FAIL abort_now: ready=%b done=%b product=%h, required 1 0 00",
                  ready_m, done_m, product_m);
      end
      @(posedge clk); #1;
      nvec++;
      if (ready_m !== 1'b1 || done_m !== 1'b0) begin
         nerr++;
         $display("FAIL abort_edge: ready=%b done=%b, required 1 0", ready_m, done_m);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(1, 4'd7, 4'd7, p, cyc, tog);
      $display("after abort 7 x 7 -> product=%h done_cycle=%0d", p, cyc);
      nvec++;
      if (p !== 8'h31 || cyc != 7) begin
         nerr++;
         $display("FAIL post_abort: product=%h cycle=%0d, required 31 7", p, cyc);
      end
   endtask

   task automatic test_sweep(input int s);
      logic [7:0] p;
      logic [7:0] pe;
      int cyc, tog, e, errs;
      errs = 0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op(s, 4'(a), 4'(b), p, cyc, tog);
            e  = (a > 7 ? a - 16 : a) * (b > 7 ? b - 16 : b);
            pe = 8'(e);
            nvec++;
            if (p !== pe || cyc < 0) begin
               nerr++; errs++;
               $display("FAIL sweep_lat%0d: %0d x %0d product=%h cycle=%0d, required %h",
                        s, (a > 7 ? a - 16 : a), (b > 7 ? b - 16 : b), p, cyc, pe);
            end
         end
      end
      $display("sweep lat%0d: 256 products, %0d wrong", s, errs);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_in_wait();
      test_sweep(0);
      test_sweep(2);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
